// File: rtl/gf_exp_sequencer.sv
// gf_exp_sequencer: left-to-right square-and-multiply controller that
// drives the shared carry-less GF ALU to compute base^exponent mod poly.
module gf_exp_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          start,
    input  logic                          abort,
    input  logic [DATA_WIDTH-1:0]         base,
    input  logic [DATA_WIDTH-1:0]         exponent,
    input  logic [$clog2(DATA_WIDTH):0]   width,
    input  logic [DATA_WIDTH:0]           poly,
    output logic                          busy,
    output logic                          done,
    output logic                          aborted,
    output logic                          err,
    output logic [DATA_WIDTH-1:0]         result,
    output logic                          alu_op_enable,
    input  logic                          alu_op_finish,
    output logic                          alu_exp_funct,
    output logic                          alu_red_funct,
    output logic                          alu_carry_option,
    output logic                          alu_sum_funct,
    output logic [$clog2(DATA_WIDTH):0]   alu_in_width,
    output logic [DATA_WIDTH:0]           alu_polyn_red_in,
    output logic [DATA_WIDTH-1:0]         alu_in_a,
    output logic [DATA_WIDTH-1:0]         alu_in_b,
    input  logic [DATA_WIDTH-1:0]         alu_out_poly
);

    localparam int IW = $clog2(DATA_WIDTH);
    localparam int WW = IW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQ_ISSUE,
        S_SQ_WAIT,
        S_MUL_ISSUE,
        S_MUL_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] base_q;
    logic [DATA_WIDTH-1:0] exp_q;
    logic [DATA_WIDTH-1:0] acc;
    logic [IW-1:0]         idx;
    logic [IW-1:0]         msb;
    logic                  abort_pend;
    logic                  width_bad;

    // Leading-one position of the latched exponent.
    always_comb begin
        msb = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (exp_q[i]) begin
                msb = IW'(i);
            end
        end
    end

    assign width_bad = (alu_in_width == '0) ||
                       (alu_in_width > WW'(DATA_WIDTH));

    // Job sequencer: one state register plus all registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state            <= S_IDLE;
            busy             <= 1'b0;
            done             <= 1'b0;
            aborted          <= 1'b0;
            err              <= 1'b0;
            result           <= '0;
            alu_op_enable    <= 1'b0;
            alu_exp_funct    <= 1'b0;
            alu_red_funct    <= 1'b0;
            alu_carry_option <= 1'b0;
            alu_sum_funct    <= 1'b0;
            alu_in_width     <= WW'(DATA_WIDTH);
            alu_polyn_red_in <= '0;
            alu_in_a         <= '0;
            alu_in_b         <= '0;
            base_q           <= '0;
            exp_q            <= '0;
            acc              <= '0;
            idx              <= '0;
            abort_pend       <= 1'b0;
        end else begin
            done          <= 1'b0;
            aborted       <= 1'b0;
            alu_op_enable <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        base_q           <= base;
                        exp_q            <= exponent;
                        alu_in_width     <= width;
                        alu_polyn_red_in <= poly;
                        alu_red_funct    <= 1'b1;
                        alu_carry_option <= 1'b0;
                        alu_sum_funct    <= 1'b0;
                        err              <= 1'b0;
                        abort_pend       <= 1'b0;
                        busy             <= 1'b1;
                        state            <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (abort) begin
                        aborted       <= 1'b1;
                        busy          <= 1'b0;
                        alu_red_funct <= 1'b0;
                        state         <= S_IDLE;
                    end else if (width_bad) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (exp_q == '0) begin
                        acc    <= DATA_WIDTH'(1);
                        result <= DATA_WIDTH'(1);
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else if (msb == '0) begin
                        acc    <= base_q;
                        result <= base_q;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        acc   <= base_q;
                        idx   <= msb - IW'(1);
                        state <= S_SQ_ISSUE;
                    end
                end
                S_SQ_ISSUE: begin
                    if (abort) begin
                        aborted       <= 1'b1;
                        busy          <= 1'b0;
                        alu_red_funct <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        alu_op_enable <= 1'b1;
                        alu_in_a      <= acc;
                        alu_in_b      <= acc;
                        alu_exp_funct <= 1'b1;
                        state         <= S_SQ_WAIT;
                    end
                end
                S_SQ_WAIT: begin
                    if (alu_op_finish) begin
                        acc <= alu_out_poly;
                        if (abort || abort_pend) begin
                            aborted       <= 1'b1;
                            busy          <= 1'b0;
                            alu_red_funct <= 1'b0;
                            state         <= S_IDLE;
                        end else if (exp_q[idx]) begin
                            state <= S_MUL_ISSUE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                S_MUL_ISSUE: begin
                    if (abort) begin
                        aborted       <= 1'b1;
                        busy          <= 1'b0;
                        alu_red_funct <= 1'b0;
                        state         <= S_IDLE;
                    end else begin
                        alu_op_enable <= 1'b1;
                        alu_in_a      <= acc;
                        alu_in_b      <= base_q;
                        alu_exp_funct <= 1'b0;
                        state         <= S_MUL_WAIT;
                    end
                end
                S_MUL_WAIT: begin
                    if (alu_op_finish) begin
                        acc <= alu_out_poly;
                        if (abort || abort_pend) begin
                            aborted       <= 1'b1;
                            busy          <= 1'b0;
                            alu_red_funct <= 1'b0;
                            state         <= S_IDLE;
                        end else begin
                            state <= S_NEXT;
                        end
                    end else if (abort) begin
                        abort_pend <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (abort) begin
                        aborted       <= 1'b1;
                        busy          <= 1'b0;
                        alu_red_funct <= 1'b0;
                        state         <= S_IDLE;
                    end else if (idx == '0) begin
                        result <= acc;
                        done   <= 1'b1;
                        state  <= S_DONE;
                    end else begin
                        idx   <= idx - IW'(1);
                        state <= S_SQ_ISSUE;
                    end
                end
                S_DONE: begin
                    busy          <= 1'b0;
                    alu_red_funct <= 1'b0;
                    state         <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
